ibus_issue_ctrl: RTL and testbench
==================================

IBUS_ISSUE_CTRL -- requirements
Module: ibus_issue_ctrl

Interface
REQ-001 Parameter SLOW_CYCLES, default 3: wait cycles inserted before completing a DIV/MOD read.
REQ-002 Parameter COM_TIMEOUT, default 15: maximum wait cycles for a COMAR/COMDR read.
REQ-003 Port clk, input, 1: single clock; all state updates on posedge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port cpu_instr, input, 13: fetched instruction word, {imm, dst[3:0], src[7:0]}.
REQ-006 Port cpu_valid, input, 1: cpu_instr is valid this cycle.
REQ-007 Port dbg_req, input, 1: debug requester asks to issue dbg_instr; held until granted.
REQ-008 Port dbg_instr, input, 13: debug instruction word, same format as cpu_instr.
REQ-009 Port com_ready, input, 1: COM block has read data valid.
REQ-010 Port bus_instr, output, 13: instruction word driven to the IBus instr input.
REQ-011 Port cpu_stall, output, 1: PC/fetch holds; cpu_instr is not consumed this cycle.
REQ-012 Port dbg_gnt, output, 1: one-cycle pulse; dbg_instr is issued this cycle.
REQ-013 Port com_timeout, output, 1: sticky flag; a COM read was forced to complete by timeout.

Function
REQ-014 NOP word = {imm=0, dst=4'd15, src=8'd0}; dst 15 matches no port, and src NULL drives no port.
REQ-015 States: ISSUE, SLOW_WAIT, COM_WAIT, DBG.
REQ-016 Slow instruction = imm=0 and src in {18 DIV, 19 MOD}; COM instruction = imm=0 and src in {30 COMAR, 31 COMDR}; imm=1 words are never slow.
REQ-017 ISSUE, cpu_valid=1, plain instruction: bus_instr=cpu_instr combinationally, cpu_stall=0, single cycle.
REQ-018 ISSUE, cpu_valid=0: bus_instr=NOP, cpu_stall=0.
REQ-019 ISSUE, slow instruction: latch the word, go to SLOW_WAIT, load counter with SLOW_CYCLES, cpu_stall=1, bus_instr={0,4'd15,src}.
REQ-020 SLOW_WAIT: bus_instr={0,4'd15,latched src}, cpu_stall=1, counter decrements each cycle; when counter==1, bus_instr=full latched word, cpu_stall=0, next state ISSUE.
REQ-021 Total occupancy of a slow instruction is SLOW_CYCLES+1 cycles; the destination sees exactly one write, in the last cycle.
REQ-022 ISSUE, COM instruction: latch the word, go to COM_WAIT, clear the wait counter, cpu_stall=1, bus_instr={0,4'd15,src}.
REQ-023 COM_WAIT: on com_ready=1 or counter==COM_TIMEOUT, drive the full latched word, cpu_stall=0, then go to ISSUE; otherwise drive the dst-masked word and increment the counter.
REQ-024 Completion with com_ready=0 at COM_TIMEOUT sets com_timeout=1; only reset clears it.
REQ-025 com_ready=1 in the first COM_WAIT cycle completes the read there; com_ready in ISSUE is ignored.
REQ-026 dbg_req is sampled only in ISSUE; a CPU instruction is never interrupted mid-wait.
REQ-027 ISSUE with dbg_req=1 and no debug issue since the last CPU instruction: go to DBG; in that cycle bus_instr=dbg_instr, dbg_gnt=1, cpu_stall=1.
REQ-028 Fairness: after a DBG cycle, the next ISSUE cycle with cpu_valid=1 serves the CPU even if dbg_req=1; dbg_req then alternates with the CPU.
REQ-029 A debug word that is slow or COM is issued unmasked for one cycle; there is no wait for debug words.
REQ-030 DBG returns to ISSUE unconditionally after one cycle.
REQ-031 Counters are 4 bits wide; parameter values above 15 are illegal.

Reset
REQ-032 On rst=1 (async): state=ISSUE, counters=0, fairness flag clear, com_timeout=0.
REQ-033 While rst=1: bus_instr=NOP, cpu_stall=0, dbg_gnt=0.
REQ-034 Reset during SLOW_WAIT or COM_WAIT abandons the latched instruction; no destination write occurs.

Verification
REQ-035 Issue cpu_instr={0,4'd0,8'd3} with cpu_valid=1 -> bus_instr=0x003 in the same cycle, cpu_stall=0.
REQ-036 Issue DIV {0,4'd1,8'd18} -> 3 cycles of bus_instr={0,15,18} with cpu_stall=1, then 1 cycle of {0,1,18} with cpu_stall=0.
REQ-037 Issue COMDR {0,4'd0,8'd31} with com_ready asserted 5 cycles later -> masked word for 5 cycles, full word on the 6th, com_timeout=0.
REQ-038 Issue COMDR with com_ready held 0 -> full word issued when counter reaches 15, com_timeout=1 and remains 1 until rst.
REQ-039 Hold dbg_req=1 with continuous cpu_valid=1 -> DBG and CPU cycles alternate, dbg_gnt pulses every other cycle, cpu_stall=1 only on DBG cycles.
REQ-040 Assert rst asynchronously in the 2nd SLOW_WAIT cycle -> bus_instr=NOP immediately, state=ISSUE, no unmasked DIV word is ever issued.

Source files
------------

// File: rtl/ibus_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ibus_issue_ctrl
// Description : Arbitrates CPU and debug instruction issue onto the IBus and
//               stretches slow (DIV/MOD) and COM reads with dst-masked words.
// Revision    : 1.0 - initial release
// ============================================================================
module ibus_issue_ctrl #(
    parameter int SLOW_CYCLES = 3,
    parameter int COM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] cpu_instr,
    input  logic        cpu_valid,
    input  logic        dbg_req,
    input  logic [12:0] dbg_instr,
    input  logic        com_ready,
    output logic [12:0] bus_instr,
    output logic        cpu_stall,
    output logic        dbg_gnt,
    output logic        com_timeout
);

    localparam logic [12:0] c_nop_word  = {1'b0, 4'd15, 8'd0};
    localparam logic [3:0]  c_slow_load = 4'(SLOW_CYCLES);
    localparam logic [3:0]  c_tmo_limit = 4'(COM_TIMEOUT);

    typedef enum logic [1:0] {
        ST_ISSUE     = 2'd0,
        ST_SLOW_WAIT = 2'd1,
        ST_COM_WAIT  = 2'd2,
        ST_DBG       = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [12:0] r_word;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic        r_dbg_done;
    logic        w_dbg_done_next;
    logic        r_com_timeout;
    logic        w_timeout_set;
    logic        w_latch;
    logic [12:0] w_bus;
    logic        w_stall;
    logic        w_gnt;

    logic [7:0]  w_src;
    logic        w_cpu_slow;
    logic        w_cpu_com;
    logic [12:0] w_cpu_masked;
    logic [12:0] w_word_masked;

    assign w_src         = cpu_instr[7:0];
    assign w_cpu_slow    = cpu_valid && !cpu_instr[12] && (w_src == 8'd18 || w_src == 8'd19);
    assign w_cpu_com     = cpu_valid && !cpu_instr[12] && (w_src == 8'd30 || w_src == 8'd31);
    // dst 15 keeps the source side active while no destination is written
    assign w_cpu_masked  = {1'b0, 4'd15, cpu_instr[7:0]};
    assign w_word_masked = {1'b0, 4'd15, r_word[7:0]};

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_dbg_done_next = r_dbg_done;
        w_timeout_set   = 1'b0;
        w_latch         = 1'b0;
        w_bus           = c_nop_word;
        w_stall         = 1'b0;
        w_gnt           = 1'b0;
        case (r_state)
            ST_ISSUE: begin
                if (w_cpu_slow) begin
                    w_latch         = 1'b1;
                    w_cnt_next      = c_slow_load;
                    w_stall         = 1'b1;
                    w_bus           = w_cpu_masked;
                    w_dbg_done_next = 1'b0;
                    w_state_next    = ST_SLOW_WAIT;
                end else if (w_cpu_com) begin
                    w_latch         = 1'b1;
                    w_cnt_next      = 4'd0;
                    w_stall         = 1'b1;
                    w_bus           = w_cpu_masked;
                    w_dbg_done_next = 1'b0;
                    w_state_next    = ST_COM_WAIT;
                end else begin
                    if (cpu_valid) begin
                        w_bus           = cpu_instr;
                        w_dbg_done_next = 1'b0;
                    end
                    // debug may go only once per CPU instruction
                    if (dbg_req && (cpu_valid || !r_dbg_done)) begin
                        w_state_next = ST_DBG;
                    end
                end
            end
            ST_SLOW_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_bus        = r_word;
                    w_state_next = ST_ISSUE;
                end else begin
                    w_bus      = w_word_masked;
                    w_stall    = 1'b1;
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            ST_COM_WAIT: begin
                if (com_ready || r_cnt == c_tmo_limit) begin
                    w_bus         = r_word;
                    w_timeout_set = !com_ready;
                    w_state_next  = ST_ISSUE;
                end else begin
                    w_bus      = w_word_masked;
                    w_stall    = 1'b1;
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            ST_DBG: begin
                w_bus           = dbg_instr;
                w_gnt           = 1'b1;
                w_stall         = 1'b1;
                w_dbg_done_next = 1'b1;
                w_state_next    = ST_ISSUE;
            end
            default: w_state_next = ST_ISSUE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_ISSUE;
            r_cnt         <= 4'd0;
            r_word        <= 13'd0;
            r_dbg_done    <= 1'b0;
            r_com_timeout <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_dbg_done <= w_dbg_done_next;
            if (w_latch) begin
                r_word <= cpu_instr;
            end
            if (w_timeout_set) begin
                r_com_timeout <= 1'b1;
            end
        end
    end

    // outputs are forced idle for the whole reset, not only after the edge
    assign bus_instr   = rst ? c_nop_word : w_bus;
    assign cpu_stall   = rst ? 1'b0 : w_stall;
    assign dbg_gnt     = rst ? 1'b0 : w_gnt;
    assign com_timeout = r_com_timeout;

endmodule
`default_nettype wire

// File: tb/tb_ibus_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibus_issue_ctrl
// Description : Self-checking bench for ibus_issue_ctrl against a queue-based
//               reference model; directed scenarios followed by random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibus_issue_ctrl;

    localparam int SLOW_CYCLES = 3;
    localparam int COM_TIMEOUT = 15;
    localparam logic [12:0] c_nop = 13'h0F00;

    logic        clk;
    logic        rst;
    logic [12:0] cpu_instr;
    logic        cpu_valid;
    logic        dbg_req;
    logic [12:0] dbg_instr;
    logic        com_ready;
    logic [12:0] bus_instr;
    logic        cpu_stall;
    logic        dbg_gnt;
    logic        com_timeout;

    ibus_issue_ctrl #(
        .SLOW_CYCLES (SLOW_CYCLES),
        .COM_TIMEOUT (COM_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_instr   (cpu_instr),
        .cpu_valid   (cpu_valid),
        .dbg_req     (dbg_req),
        .dbg_instr   (dbg_instr),
        .com_ready   (com_ready),
        .bus_instr   (bus_instr),
        .cpu_stall   (cpu_stall),
        .dbg_gnt     (dbg_gnt),
        .com_timeout (com_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: a slow read is a pre-computed script of outputs,
    // a COM read counts waited cycles, debug fairness compares cycle stamps.
    logic [13:0] m_q[$];
    bit          m_com;
    logic [12:0] m_com_word;
    int          m_waits;
    bit          m_dbg_next;
    int          m_cyc;
    int          m_last_cpu;
    int          m_last_dbg;
    bit          m_tmo;

    function automatic logic [12:0] masked(input logic [12:0] w);
        return {1'b0, 4'd15, w[7:0]};
    endfunction

    function automatic logic [12:0] rand_word();
        logic [7:0] s;
        case ($urandom % 6)
            0:       s = 8'd18;
            1:       s = 8'd19;
            2:       s = 8'd30;
            3:       s = 8'd31;
            default: s = 8'($urandom);
        endcase
        return {($urandom % 5 == 0), 4'($urandom), s};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_com      = 0;
        m_waits    = 0;
        m_dbg_next = 0;
        m_cyc      = 0;
        m_last_cpu = -1;
        m_last_dbg = -2;
        m_tmo      = 0;
    endtask

    // Entered 1 time unit after a rising edge; returns at the same point of the next cycle.
    task automatic cycle(input logic v, input logic [12:0] ci, input logic dr,
                         input logic [12:0] di, input logic cr, output logic granted);
        logic [12:0] eb;
        logic        es;
        logic        eg;
        logic        tset;
        logic [13:0] ent;
        logic [7:0]  s;
        cpu_valid = v;
        cpu_instr = ci;
        dbg_req   = dr;
        dbg_instr = di;
        com_ready = cr;
        #3;
        eb = c_nop; es = 1'b0; eg = 1'b0; tset = 1'b0; s = ci[7:0];
        if (m_q.size() != 0) begin
            ent = m_q.pop_front();
            es  = ent[13];
            eb  = ent[12:0];
        end else if (m_com) begin
            if (cr || m_waits == COM_TIMEOUT) begin
                eb    = m_com_word;
                tset  = !cr;
                m_com = 0;
            end else begin
                eb = masked(m_com_word);
                es = 1'b1;
                m_waits++;
            end
        end else if (m_dbg_next) begin
            eb = di; es = 1'b1; eg = 1'b1;
            m_dbg_next = 0;
            m_last_dbg = m_cyc;
        end else if (v && !ci[12] && (s == 8'd18 || s == 8'd19)) begin
            eb = masked(ci); es = 1'b1;
            m_last_cpu = m_cyc;
            for (int k = 0; k < SLOW_CYCLES - 1; k++) m_q.push_back({1'b1, masked(ci)});
            m_q.push_back({1'b0, ci});
        end else if (v && !ci[12] && (s == 8'd30 || s == 8'd31)) begin
            eb = masked(ci); es = 1'b1;
            m_last_cpu = m_cyc;
            m_com      = 1;
            m_com_word = ci;
            m_waits    = 0;
        end else begin
            if (v) begin
                eb = ci;
                m_last_cpu = m_cyc;
            end
            if (dr && m_last_cpu > m_last_dbg) m_dbg_next = 1;
        end
        check("bus_instr",   32'(bus_instr),   32'(eb));
        check("cpu_stall",   32'(cpu_stall),   32'(es));
        check("dbg_gnt",     32'(dbg_gnt),     32'(eg));
        check("com_timeout", 32'(com_timeout), 32'(m_tmo));
        if (tset) m_tmo = 1;
        m_cyc++;
        granted = eg;
        @(posedge clk);
        #1;
    endtask

    // Asserts rst mid-cycle (away from any edge) and checks the immediate effect.
    task automatic async_reset(input logic [12:0] ci);
        cpu_valid = 1'b1;
        cpu_instr = ci;
        dbg_req   = 1'b1;
        com_ready = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("rst_bus",   32'(bus_instr),   32'(c_nop));
        check("rst_stall", 32'(cpu_stall),   32'd0);
        check("rst_gnt",   32'(dbg_gnt),     32'd0);
        check("rst_tmo",   32'(com_timeout), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    logic        g;
    logic        hold_dbg;
    logic [12:0] hold_di;
    logic        dr_r;
    logic [12:0] di_r;

    initial begin
        rst       = 1'b1;
        cpu_valid = 1'b1;
        cpu_instr = 13'h003;
        dbg_req   = 1'b1;
        dbg_instr = 13'h0AA;
        com_ready = 1'b0;
        #2;
        check("reset_bus",   32'(bus_instr),   32'(c_nop));
        check("reset_stall", 32'(cpu_stall),   32'd0);
        check("reset_gnt",   32'(dbg_gnt),     32'd0);
        check("reset_tmo",   32'(com_timeout), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // plain instruction, same-cycle pass-through
        cycle(1'b1, 13'h003, 1'b0, 13'h0, 1'b0, g);
        // DIV {0,1,18}: three masked cycles then the full word
        for (int i = 0; i < SLOW_CYCLES + 1; i++) cycle(1'b1, 13'h112, 1'b0, 13'h0, 1'b0, g);
        cycle(1'b0, 13'h0, 1'b0, 13'h0, 1'b0, g);
        // COMDR with com_ready five cycles after issue
        for (int i = 0; i < 6; i++) cycle(1'b1, 13'h01F, 1'b0, 13'h0, (i == 5), g);
        cycle(1'b0, 13'h0, 1'b0, 13'h0, 1'b0, g);
        // COMDR timing out
        for (int i = 0; i < COM_TIMEOUT + 2; i++) cycle(1'b1, 13'h01F, 1'b0, 13'h0, 1'b0, g);
        for (int i = 0; i < 3; i++) cycle(1'b0, 13'h0, 1'b0, 13'h0, 1'b0, g);
        check("tmo_sticky", 32'(com_timeout), 32'd1);
        // debug held against continuous CPU traffic
        for (int i = 0; i < 8; i++) cycle(1'b1, 13'h1000 | 13'(i), 1'b1, 13'h0C5, 1'b0, g);
        cycle(1'b0, 13'h0, 1'b0, 13'h0, 1'b0, g);
        // reset during the second SLOW_WAIT cycle
        cycle(1'b1, 13'h112, 1'b0, 13'h0, 1'b0, g);
        cycle(1'b1, 13'h112, 1'b0, 13'h0, 1'b0, g);
        async_reset(13'h112);
        for (int i = 0; i < SLOW_CYCLES + 1; i++) cycle(1'b0, 13'h112, 1'b0, 13'h0, 1'b0, g);

        // random traffic; a pending debug request is held until granted
        hold_dbg = 1'b0;
        hold_di  = 13'h0;
        for (int n = 0; n < 1600; n++) begin
            if (n % 400 == 399) begin
                async_reset(rand_word());
                hold_dbg = 1'b0;
            end
            dr_r = hold_dbg ? 1'b1 : ($urandom % 4 == 0);
            di_r = hold_dbg ? hold_di : rand_word();
            cycle(($urandom % 4 != 0), rand_word(), dr_r, di_r, ($urandom % 8 == 0), g);
            hold_dbg = dr_r && !g;
            hold_di  = di_r;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
